instr_mem_loader: RTL and testbench

- Boot-time writer for the instruction memory.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver. Assembles little-endian 32-bit words and drives a word-wide write port into instruction RAM.
- Holds the core in reset while a program is loading, and releases it once the image is complete.
- Sits between the serial receiver and the instruction memory's write side. The core's fetch path keeps using the read side.

---
 rtl/instr_mem_loader.sv | 179 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time instruction RAM writer.
// Assembles a little-endian byte stream (word count N, then N words) into
// 32-bit RAM writes and holds the core in reset until the image is complete.
// Optional trailing checksum byte: define INSTR_MEM_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  input  logic        start_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int WCW = $clog2(MEM_WORDS + 1);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [WCW-1:0]   len_q, len_d;
  logic [23:0]      asm_q, asm_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             core_rst_q, core_rst_d;
  logic             accept;
  logic [31:0]      word_full;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  assign byte_ready_o = (state_q != S_DONE) && (state_q != S_ERR);
  assign accept       = byte_valid_i && byte_ready_o;
  assign word_full    = {byte_data_i, asm_q};
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign core_rst_o   = core_rst_q;
  assign done_o       = (state_q == S_DONE);
  assign err_o        = (state_q == S_ERR);

  // State and datapath registers; reset discards any partial word and write pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_LEN;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state: byte assembly, length bound check, word writes, completion.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    if (accept && (state_q == S_LEN || state_q == S_DATA)) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    asm_d[7:0]   = byte_data_i;
        2'd1:    asm_d[15:8]  = byte_data_i;
        2'd2:    asm_d[23:16] = byte_data_i;
        default: asm_d        = asm_q;
      endcase
    end

    case (state_q)
      S_LEN: begin
        if (accept && byte_cnt_q == 2'd3) begin
          word_cnt_d = '0;
          if (word_full > MEM_WORDS) begin
            state_d = S_ERR;
          end else begin
            len_d = word_full[WCW-1:0];
            if (word_full == '0) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
          csum_d = csum_q + byte_data_i;
`endif
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = word_full;
            addr_d     = BASE_ADDR + 32'({word_cnt_q, 2'b00});
            word_cnt_d = word_cnt_q + WCW'(1);
            if (word_cnt_q == len_q - WCW'(1)) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_d = (byte_data_i == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_LEN;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          asm_d      = '0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      default: state_d = S_LEN;
    endcase

    // Release only once DONE has already been held a cycle, so the final
    // write pulse (issued on the DONE entry edge) lands before the core runs.
    core_rst_d = !((state_q == S_DONE) && (state_d == S_DONE));
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: random and directed images are
// checked against a byte-stream reference model of the load protocol.
module tb_instr_mem_loader;

  localparam int unsigned MEM_WORDS = 1024;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        start_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        core_rst_o;
  logic        done_o;
  logic        err_o;

  instr_mem_loader #(
    .MEM_WORDS(MEM_WORDS),
    .BASE_ADDR(BASE_ADDR)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .byte_valid_i(byte_valid_i),
    .byte_data_i (byte_data_i),
    .byte_ready_o(byte_ready_o),
    .start_i     (start_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .core_rst_o  (core_rst_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_err = 0;
  int unsigned n_checks = 0;

  logic [7:0]  stim[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] got_addr[$], got_data[$];
  int unsigned cyc = 0, last_we_cyc = 0, rel_cyc = 0, drops = 0;
  logic        prev_rst = 1'b1;
  bit          streaming = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Passive monitor sampled on the falling edge.
  always @(negedge clk_i) begin
    if (mem_we_o) begin
      got_addr.push_back(mem_addr_o);
      got_data.push_back(mem_wdata_o);
      last_we_cyc <= cyc;
    end
    if (prev_rst && !core_rst_o) rel_cyc <= cyc;
    prev_rst <= core_rst_o;
    if (streaming && byte_valid_i && !byte_ready_o) drops <= drops + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void push_word(input logic [31:0] w);
    stim.push_back(w[7:0]);
    stim.push_back(w[15:8]);
    stim.push_back(w[23:16]);
    stim.push_back(w[31:24]);
  endfunction

  function automatic void build_image(input int unsigned n, input bit csum_ok);
    logic [7:0]  sum;
    logic [31:0] w;
    stim.delete();
    push_word(32'(n));
    if (n > MEM_WORDS) return;
    sum = 8'h00;
    for (int unsigned i = 0; i < n; i++) begin
      w = $urandom;
      push_word(w);
      sum = sum + w[7:0] + w[15:8] + w[23:16] + w[31:24];
    end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    stim.push_back(csum_ok ? sum : sum + 8'h01);
`else
    if (csum_ok) sum = 8'h00;
`endif
  endfunction

  // Reference model: interprets the byte stream directly.
  task automatic model_image(output int unsigned consumed, output bit exp_done,
                             output bit exp_err);
    logic [31:0] n;
    logic [7:0]  sum;
    int unsigned b;
    exp_addr.delete();
    exp_data.delete();
    n = {stim[3], stim[2], stim[1], stim[0]};
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n > MEM_WORDS) begin
      consumed = 4;
      exp_err  = 1'b1;
      return;
    end
    sum = 8'h00;
    for (int unsigned i = 0; i < n; i++) begin
      b = 4 + 4 * i;
      exp_addr.push_back(BASE_ADDR + 32'(4 * i));
      exp_data.push_back({stim[b+3], stim[b+2], stim[b+1], stim[b]});
      sum = sum + stim[b] + stim[b+1] + stim[b+2] + stim[b+3];
    end
    consumed = 4 + 4 * n;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    consumed = consumed + 1;
    if (stim[consumed-1] == sum) exp_done = 1'b1;
    else exp_err = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned n;
    repeat (gap) begin
      byte_valid_i = 1'b0;
      @(posedge clk_i); #1;
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    n = 0;
    while (!byte_ready_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!byte_ready_o) begin
      chk("ready_timeout", 32'(byte_ready_o), 32'd1);
      byte_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("start_done", 32'(done_o), 32'd0);
    chk("start_err", 32'(err_o), 32'd0);
    chk("start_corerst", 32'(core_rst_o), 32'd1);
    chk("start_ready", 32'(byte_ready_o), 32'd1);
  endtask

  task automatic run_image(input int unsigned gap_max, input string tag);
    int unsigned consumed, waitc;
    bit ed, ee;
    model_image(consumed, ed, ee);
    if (done_o || err_o) pulse_start();
    got_addr.delete();
    got_data.delete();
    drops = 0;
    streaming = 1'b1;
    for (int unsigned i = 0; i < consumed; i++)
      send_byte(stim[i], $urandom_range(0, gap_max));
    streaming = 1'b0;
    waitc = 0;
    while (!(done_o || err_o) && waitc < 20) begin
      @(posedge clk_i); #1;
      waitc++;
    end
    chk({tag, "_finished"}, 32'(done_o || err_o), 32'd1);
    repeat (3) @(posedge clk_i);
    #1;
    chk({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int unsigned i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      chk({tag, "_addr"}, got_addr[i], exp_addr[i]);
      chk({tag, "_data"}, got_data[i], exp_data[i]);
    end
    chk({tag, "_done"}, 32'(done_o), 32'(ed));
    chk({tag, "_err"}, 32'(err_o), 32'(ee));
    chk({tag, "_corerst"}, 32'(core_rst_o), 32'(!ed));
    chk({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    chk({tag, "_readydrop"}, drops, 32'd0);
    if (ed && exp_addr.size() > 0) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      chk({tag, "_rel_after_we"}, 32'(rel_cyc > last_we_cyc), 32'd1);
`else
      chk({tag, "_rel_gap"}, rel_cyc - last_we_cyc, 32'd1);
`endif
    end
  endtask

  initial begin
    int unsigned n, r;
    rst_i = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i = 8'h00;
    start_i = 1'b0;
    #12;
    chk("rst_ready", 32'(byte_ready_o), 32'd1);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, BASE_ADDR);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_corerst", 32'(core_rst_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    #10 rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Single-word image from the boot example.
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    stim.push_back(8'hB8);
`endif
    run_image(0, "one_word");

    // Back-to-back three words.
    build_image(3, 1'b1);
    run_image(0, "b2b3");

    // Oversize length, then bytes offered while in ERR, then recovery.
    stim = '{8'h01, 8'h04, 8'h00, 8'h00};
    run_image(1, "too_long");
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h55;
    repeat (3) @(posedge clk_i);
    #1;
    byte_valid_i = 1'b0;
    chk("err_nowrite", 32'(got_addr.size()), 32'd0);
    chk("err_ready", 32'(byte_ready_o), 32'd0);
    chk("err_hold", 32'(err_o), 32'd1);
    build_image(1, 1'b1);
    run_image(1, "after_err");

    // Zero-length image.
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    run_image(0, "len0");

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB9};
    run_image(0, "bad_csum");
`endif

    // Full-capacity image reaches the last RAM word.
    build_image(MEM_WORDS, 1'b1);
    run_image(0, "full");

    // Reset after two bytes of word 1 of a two-word image.
    build_image(2, 1'b1);
    model_image(n, r[0], r[1]);
    pulse_start();
    got_addr.delete();
    got_data.delete();
    for (int unsigned i = 0; i < 10; i++) send_byte(stim[i], 0);
    #2 rst_i = 1'b0;
    #1;
    chk("mid_we", 32'(mem_we_o), 32'd0);
    chk("mid_ready", 32'(byte_ready_o), 32'd1);
    chk("mid_corerst", 32'(core_rst_o), 32'd1);
    chk("mid_done", 32'(done_o), 32'd0);
    chk("mid_nwrites", 32'(got_addr.size()), 32'd1);
    if (got_addr.size() > 0) chk("mid_word0", got_data[0], exp_data[0]);
    @(posedge clk_i); #3 rst_i = 1'b1;
    @(posedge clk_i); #1;
    run_image(1, "resend");

    // Reset landing on a write-pulse cycle suppresses it at once.
    build_image(1, 1'b1);
    pulse_start();
    for (int unsigned i = 0; i < 8; i++) send_byte(stim[i], 0);
    chk("pulse_pre", 32'(mem_we_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("pulse_sup", 32'(mem_we_o), 32'd0);
    chk("pulse_addr", mem_addr_o, BASE_ADDR);
    @(posedge clk_i); #3 rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Randomized images.
    for (int unsigned it = 0; it < 10; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) n = MEM_WORDS + 1 + $urandom_range(0, 100);
      else n = $urandom_range(1, 6);
      build_image(n, $urandom_range(0, 3) != 0);
      run_image($urandom_range(0, 2), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
